// File: rtl/draw_scheduler_if.sv
// Frame sequencer <-> client/VGA bundle: control pulses, three client pixel streams, muxed VGA output, status.
// Latency: none; this is a plain signal bundle with no logic.
// Backpressure: none; start/done pulses carry all flow control between sequencer and clients.
//
// Ports (by modport):
//   master : the sequencer. Inputs are frame_tick, game_over, *_done and the client pixels.
//            Outputs are *_start, grant, vga_*, update_en, busy, timeout_flag and overrun_cnt.
//   slave  : the environment (clients, VGA adapter, game logic), with the same signals reversed.
interface draw_scheduler_if #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int COL_W = 3
);
    // Frame control and client completion pulses
    logic             frame_tick;
    logic             game_over;
    logic             bg_done;
    logic             wall_done;
    logic             bird_done;

    // Client pixel streams
    logic [X_W-1:0]   bg_x;
    logic [Y_W-1:0]   bg_y;
    logic [COL_W-1:0] bg_col;
    logic             bg_plot;
    logic [X_W-1:0]   wall_x;
    logic [Y_W-1:0]   wall_y;
    logic [COL_W-1:0] wall_col;
    logic             wall_plot;
    logic [X_W-1:0]   bird_x;
    logic [Y_W-1:0]   bird_y;
    logic [COL_W-1:0] bird_col;
    logic             bird_plot;

    // Sequencer outputs
    logic             bg_start;
    logic             wall_start;
    logic             bird_start;
    logic [2:0]       grant;
    logic [X_W-1:0]   vga_x;
    logic [Y_W-1:0]   vga_y;
    logic [COL_W-1:0] vga_col;
    logic             vga_plot;
    logic             update_en;
    logic             busy;
    logic             timeout_flag;
    logic [7:0]       overrun_cnt;

    modport master (
        input  frame_tick, game_over, bg_done, wall_done, bird_done,
        input  bg_x, bg_y, bg_col, bg_plot,
        input  wall_x, wall_y, wall_col, wall_plot,
        input  bird_x, bird_y, bird_col, bird_plot,
        output bg_start, wall_start, bird_start, grant,
        output vga_x, vga_y, vga_col, vga_plot,
        output update_en, busy, timeout_flag, overrun_cnt
    );

    modport slave (
        output frame_tick, game_over, bg_done, wall_done, bird_done,
        output bg_x, bg_y, bg_col, bg_plot,
        output wall_x, wall_y, wall_col, wall_plot,
        output bird_x, bird_y, bird_col, bird_plot,
        input  bg_start, wall_start, bird_start, grant,
        input  vga_x, vga_y, vga_col, vga_plot,
        input  update_en, busy, timeout_flag, overrun_cnt
    );
endinterface

// File: rtl/draw_scheduler.sv
// Per-frame sequencer (background -> walls -> bird -> update) that arbitrates the single VGA plot port.
// Latency: a start pulse follows 1 cycle after frame_tick or after the previous done; the pixel mux has zero latency.
// Backpressure: none; a frame_tick that arrives while busy is dropped and counted in overrun_cnt.
//
// Ports:
//   clk          system clock
//   resetn       synchronous active-low reset; clients must share it
//   bus.master   frame_tick/game_over/*_done/client pixels in;
//                *_start, grant, vga_*, update_en, busy, timeout_flag, overrun_cnt out
module draw_scheduler #(
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int COL_W       = 3,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic            clk,
    input  logic            resetn,
    draw_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BG     = 3'd1,
        WALL   = 3'd2,
        BIRD   = 3'd3,
        UPDATE = 3'd4
    } state_t;

    // The phase counter starts at 0 in the phase's first cycle.
    // Firing at TIMEOUT_CYC-1 therefore gives each phase exactly TIMEOUT_CYC cycles.
    localparam logic [15:0] PHASE_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_n;
    logic        first_q;         // high during the first cycle of any state
    logic [15:0] phase_cnt;
    logic        bg_start_q;
    logic        wall_start_q;
    logic        bird_start_q;
    logic        update_q;
    logic        timeout_q;
    logic [7:0]  overrun_q;

    logic        done_sel;        // done from the granted client, first cycle excluded
    logic        phase_expired;
    logic        timeout_hit;
    logic        entering;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_n       = state;
        done_sel      = 1'b0;
        timeout_hit   = 1'b0;
        phase_expired = (phase_cnt == PHASE_LAST);

        // Only the granted client's done is looked at.
        // A done in the start cycle is treated as stale and ignored.
        case (state)
            BG:      done_sel = bus.bg_done   && !first_q;
            WALL:    done_sel = bus.wall_done && !first_q;
            BIRD:    done_sel = bus.bird_done && !first_q;
            default: done_sel = 1'b0;
        endcase

        case (state)
            IDLE: begin
                if (bus.frame_tick) state_n = BG;
            end
            BG: begin
                if (done_sel || phase_expired) begin
                    state_n     = WALL;
                    timeout_hit = !done_sel;
                end
            end
            WALL: begin
                if (done_sel || phase_expired) begin
                    state_n     = BIRD;
                    timeout_hit = !done_sel;
                end
            end
            BIRD: begin
                if (done_sel || phase_expired) begin
                    state_n     = UPDATE;
                    timeout_hit = !done_sel;
                end
            end
            UPDATE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase

        entering = (state_n != state);
    end

    // ---------------------------------------------------------------------
    // State and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            first_q      <= 1'b0;
            phase_cnt    <= '0;
            bg_start_q   <= 1'b0;
            wall_start_q <= 1'b0;
            bird_start_q <= 1'b0;
            update_q     <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= '0;
        end else begin
            state        <= state_n;
            first_q      <= entering;
            phase_cnt    <= (entering || state == IDLE) ? 16'd0 : phase_cnt + 16'd1;
            bg_start_q   <= entering && (state_n == BG);
            wall_start_q <= entering && (state_n == WALL);
            bird_start_q <= entering && (state_n == BIRD);
            // game_over is sampled on the way into UPDATE; the frame itself is always drawn.
            update_q     <= entering && (state_n == UPDATE) && !bus.game_over;
            timeout_q    <= timeout_q | timeout_hit;
            // Any tick outside IDLE, the UPDATE cycle included, is a lost frame.
            if (bus.frame_tick && state != IDLE && overrun_q != 8'hFF)
                overrun_q <= overrun_q + 8'd1;
        end
    end

    // ---------------------------------------------------------------------
    // Grant and pixel mux (combinational from state)
    // ---------------------------------------------------------------------
    logic [2:0]       grant_c;
    logic [X_W-1:0]   mux_x;
    logic [Y_W-1:0]   mux_y;
    logic [COL_W-1:0] mux_col;
    logic             mux_plot;

    always_comb begin
        grant_c  = 3'b000;
        mux_x    = '0;
        mux_y    = '0;
        mux_col  = '0;
        mux_plot = 1'b0;
        case (state)
            BG: begin
                grant_c  = 3'b001;
                mux_x    = bus.bg_x;
                mux_y    = bus.bg_y;
                mux_col  = bus.bg_col;
                mux_plot = bus.bg_plot;
            end
            WALL: begin
                grant_c  = 3'b010;
                mux_x    = bus.wall_x;
                mux_y    = bus.wall_y;
                mux_col  = bus.wall_col;
                mux_plot = bus.wall_plot;
            end
            BIRD: begin
                grant_c  = 3'b100;
                mux_x    = bus.bird_x;
                mux_y    = bus.bird_y;
                mux_col  = bus.bird_col;
                mux_plot = bus.bird_plot;
            end
            default: ;
        endcase
    end

    assign bus.grant        = grant_c;
    assign bus.vga_x        = mux_x;
    assign bus.vga_y        = mux_y;
    assign bus.vga_col      = mux_col;
    assign bus.vga_plot     = mux_plot;
    assign bus.bg_start     = bg_start_q;
    assign bus.wall_start   = wall_start_q;
    assign bus.bird_start   = bird_start_q;
    assign bus.update_en    = update_q;
    assign bus.busy         = (state != IDLE);
    assign bus.timeout_flag = timeout_q;
    assign bus.overrun_cnt  = overrun_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: nominal frame table plus timeout, overrun and mid-frame reset sequences.
// Latency: outputs are checked 1 ns after the falling edge, with inputs changed on that same falling edge.
// Backpressure: not applicable; every wait is bounded by a cycle budget and a global watchdog.
module tb_draw_scheduler;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    draw_scheduler_if #(.X_W(8), .Y_W(7), .COL_W(3)) b1();
    draw_scheduler_if #(.X_W(8), .Y_W(7), .COL_W(3)) b2();

    draw_scheduler #(.X_W(8), .Y_W(7), .COL_W(3), .TIMEOUT_CYC(65535)) dut1 (
        .clk(clk), .resetn(resetn), .bus(b1));
    draw_scheduler #(.X_W(8), .Y_W(7), .COL_W(3), .TIMEOUT_CYC(8)) dut2 (
        .clk(clk), .resetn(resetn), .bus(b2));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // done bits are {bird, wall, bg}
    task automatic set1(input bit tick, input logic [2:0] done);
        b1.frame_tick = tick;
        b1.bg_done    = done[0];
        b1.wall_done  = done[1];
        b1.bird_done  = done[2];
    endtask

    typedef struct {
        bit         tick;
        logic [2:0] done;
        logic [2:0] st;     // expected {bird,wall,bg}_start
        logic [2:0] g;      // expected grant
        bit         upd;
        bit         busy;
        logic [7:0] x;      // expected vga_x
        bit         plot;   // expected vga_plot
    } vec_t;

    function automatic vec_t v(bit tick, logic [2:0] done, logic [2:0] st, logic [2:0] g,
                               bit upd, bit busy, logic [7:0] x, bit plot);
        vec_t r;
        r.tick = tick; r.done = done; r.st = st; r.g = g;
        r.upd = upd; r.busy = busy; r.x = x; r.plot = plot;
        return r;
    endfunction

    vec_t tbl[21];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        bit seen;

        // Constant client pixels: bg=(77,55,5), wall=(10,20,2), bird=(33,44,7), all plotting.
        b1.bg_x = 8'd77;   b1.bg_y = 7'd55;   b1.bg_col = 3'd5;   b1.bg_plot = 1'b1;
        b1.wall_x = 8'd10; b1.wall_y = 7'd20; b1.wall_col = 3'd2; b1.wall_plot = 1'b1;
        b1.bird_x = 8'd33; b1.bird_y = 7'd44; b1.bird_col = 3'd7; b1.bird_plot = 1'b1;
        b1.game_over = 1'b0;
        set1(1'b0, 3'b000);
        b2.bg_x = 8'd1;    b2.bg_y = 7'd1;    b2.bg_col = 3'd1;   b2.bg_plot = 1'b0;
        b2.wall_x = 8'd2;  b2.wall_y = 7'd2;  b2.wall_col = 3'd2; b2.wall_plot = 1'b0;
        b2.bird_x = 8'd3;  b2.bird_y = 7'd3;  b2.bird_col = 3'd3; b2.bird_plot = 1'b0;
        b2.game_over = 1'b0;
        b2.frame_tick = 1'b0; b2.bg_done = 1'b0; b2.wall_done = 1'b0; b2.bird_done = 1'b0;

        // Nominal frame starting at cycle 0. Done pulses arrive 5 cycles after each start.
        // Stray and same-cycle dones sit in the BG phase; a tick in the UPDATE cycle is an overrun.
        tbl[0]  = v(1, 3'b000, 3'b000, 3'b000, 0, 0, 8'd0,  0);
        tbl[1]  = v(0, 3'b001, 3'b001, 3'b001, 0, 1, 8'd77, 1); // bg_done with bg_start: ignored
        tbl[2]  = v(0, 3'b010, 3'b000, 3'b001, 0, 1, 8'd77, 1); // stray wall_done
        tbl[3]  = v(0, 3'b100, 3'b000, 3'b001, 0, 1, 8'd77, 1); // stray bird_done
        tbl[4]  = v(0, 3'b000, 3'b000, 3'b001, 0, 1, 8'd77, 1);
        tbl[5]  = v(0, 3'b000, 3'b000, 3'b001, 0, 1, 8'd77, 1);
        tbl[6]  = v(0, 3'b001, 3'b000, 3'b001, 0, 1, 8'd77, 1);
        tbl[7]  = v(0, 3'b000, 3'b010, 3'b010, 0, 1, 8'd10, 1);
        tbl[8]  = v(0, 3'b000, 3'b000, 3'b010, 0, 1, 8'd10, 1);
        tbl[9]  = v(0, 3'b000, 3'b000, 3'b010, 0, 1, 8'd10, 1);
        tbl[10] = v(0, 3'b000, 3'b000, 3'b010, 0, 1, 8'd10, 1);
        tbl[11] = v(0, 3'b000, 3'b000, 3'b010, 0, 1, 8'd10, 1);
        tbl[12] = v(0, 3'b010, 3'b000, 3'b010, 0, 1, 8'd10, 1);
        tbl[13] = v(0, 3'b000, 3'b100, 3'b100, 0, 1, 8'd33, 1);
        tbl[14] = v(0, 3'b000, 3'b000, 3'b100, 0, 1, 8'd33, 1);
        tbl[15] = v(0, 3'b000, 3'b000, 3'b100, 0, 1, 8'd33, 1);
        tbl[16] = v(0, 3'b000, 3'b000, 3'b100, 0, 1, 8'd33, 1);
        tbl[17] = v(0, 3'b000, 3'b000, 3'b100, 0, 1, 8'd33, 1);
        tbl[18] = v(0, 3'b100, 3'b000, 3'b100, 0, 1, 8'd33, 1);
        tbl[19] = v(1, 3'b000, 3'b000, 3'b000, 1, 1, 8'd0,  0); // UPDATE; tick here is dropped
        tbl[20] = v(0, 3'b000, 3'b000, 3'b000, 0, 0, 8'd0,  0);

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy",    b1.busy, 0);
        chk("rst_grant",   b1.grant, 0);
        chk("rst_starts",  {b1.bird_start, b1.wall_start, b1.bg_start}, 0);
        chk("rst_update",  b1.update_en, 0);
        chk("rst_timeout", b1.timeout_flag, 0);
        chk("rst_overrun", b1.overrun_cnt, 0);
        chk("rst_plot",    b1.vga_plot, 0);
        chk("rst_x",       b1.vga_x, 0);
        resetn = 1'b1;

        // ---------------- nominal frame table ----------------
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            set1(tbl[i].tick, tbl[i].done);
            #1;
            chk($sformatf("v%0d_start", i), {b1.bird_start, b1.wall_start, b1.bg_start}, tbl[i].st);
            chk($sformatf("v%0d_grant", i), b1.grant, tbl[i].g);
            chk($sformatf("v%0d_upd", i), b1.update_en, tbl[i].upd);
            chk($sformatf("v%0d_busy", i), b1.busy, tbl[i].busy);
            chk($sformatf("v%0d_vga_x", i), b1.vga_x, tbl[i].x);
            chk($sformatf("v%0d_plot", i), b1.vga_plot, tbl[i].plot);
            if (i == 8) begin
                chk("wall_vga_y", b1.vga_y, 20);
                chk("wall_vga_col", b1.vga_col, 3'b010);
            end
        end
        @(negedge clk);
        set1(1'b0, 3'b000);
        #1;
        chk("update_tick_overrun", b1.overrun_cnt, 1);
        chk("update_tick_no_frame", b1.busy, 0);
        chk("update_tick_no_start", b1.bg_start, 0);

        // ---------------- timeout (TIMEOUT_CYC=8, wall never done) ----------------
        @(negedge clk); b2.frame_tick = 1'b1;
        @(negedge clk); b2.frame_tick = 1'b0;
        #1;
        chk("to_bg_start", b2.bg_start, 1);
        @(negedge clk); b2.bg_done = 1'b1;
        @(negedge clk); b2.bg_done = 1'b0;
        #1;
        chk("to_wall_start", b2.wall_start, 1);
        chk("to_flag_before", b2.timeout_flag, 0);
        found = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            #1;
            if (b2.bird_start) begin
                found = n;
                break;
            end
        end
        chk("to_wall_len", found, 8);
        chk("to_flag_set", b2.timeout_flag, 1);
        @(negedge clk); b2.bird_done = 1'b1;
        @(negedge clk); b2.bird_done = 1'b0;
        #1;
        chk("to_update", b2.update_en, 1);
        @(negedge clk);
        #1;
        chk("to_idle", b2.busy, 0);
        chk("to_flag_sticky", b2.timeout_flag, 1);

        // ---------------- overrun + game_over ----------------
        b1.game_over = 1'b1;
        @(negedge clk); set1(1'b1, 3'b000);
        @(negedge clk); set1(1'b0, 3'b000);
        #1;
        chk("go_bg_start", b1.bg_start, 1);
        @(negedge clk); set1(1'b0, 3'b001);
        @(negedge clk); set1(1'b0, 3'b000);
        #1;
        chk("go_wall_start", b1.wall_start, 1);
        @(negedge clk); set1(1'b0, 3'b010);
        @(negedge clk); set1(1'b0, 3'b000);
        #1;
        chk("go_bird_start", b1.bird_start, 1);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            b1.frame_tick = (k % 2 == 0);
            if (k == 199) begin
                #1;
                chk("overrun_mid", b1.overrun_cnt, 101);
            end
        end
        @(negedge clk); set1(1'b0, 3'b000);
        #1;
        chk("overrun_sat", b1.overrun_cnt, 255);
        chk("overrun_grant", b1.grant, 3'b100);
        chk("overrun_busy", b1.busy, 1);
        @(negedge clk); set1(1'b0, 3'b100);
        @(negedge clk); set1(1'b0, 3'b000);
        #1;
        chk("go_update_suppressed", b1.update_en, 0);
        chk("go_update_grant", b1.grant, 0);
        chk("go_update_busy", b1.busy, 1);
        @(negedge clk);
        #1;
        chk("go_idle", b1.busy, 0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            seen |= b1.bg_start | b1.busy;
        end
        chk("no_extra_frame", seen, 0);
        b1.game_over = 1'b0;

        // ---------------- reset in BIRD ----------------
        @(negedge clk); set1(1'b1, 3'b000);
        @(negedge clk); set1(1'b0, 3'b000);
        @(negedge clk); set1(1'b0, 3'b001);
        @(negedge clk); set1(1'b0, 3'b000);
        @(negedge clk); set1(1'b0, 3'b010);
        @(negedge clk); set1(1'b0, 3'b000);
        #1;
        chk("rb_in_bird", b1.grant, 3'b100);
        @(negedge clk); resetn = 1'b0;
        @(negedge clk);
        #1;
        chk("rb_busy", b1.busy, 0);
        chk("rb_grant", b1.grant, 0);
        chk("rb_plot", b1.vga_plot, 0);
        chk("rb_x", b1.vga_x, 0);
        chk("rb_pulses", {b1.update_en, b1.bird_start, b1.wall_start, b1.bg_start}, 0);
        chk("rb_overrun", b1.overrun_cnt, 0);
        chk("rb_timeout", b2.timeout_flag, 0);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        chk("rb_stay_idle", b1.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
